fifo_demux_wr: RTL and testbench
================================

Name: fifo_demux_wr

Overview:
- Write-side router for the four-FIFO data path: accepts one 10-bit word per cycle from the upstream source.
- Steers each word into one of four FIFOs by the destination field carried in the word.
- Per-FIFO push strobes are registered.
- Back-pressure is honoured through the FIFOs' almost-full flags, with a one-word holding register and a ready handshake toward the source.

Parameters:
- WIDTH, 10, data word width in bits.
- DEST_LSB, 8, bit index of the 2-bit destination field dato_in[DEST_LSB+1:DEST_LSB]; must satisfy DEST_LSB+1 < WIDTH.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
- dato_in  input  WIDTH  incoming data word.
- valid_in  input  1  dato_in valid this cycle.
- ready_out  output  1  block can accept a word this cycle; a word transfers when valid_in && ready_out.
- almost_full  input  4  bit N = FIFO N almost-full; no push to FIFO N while set.
- fifo0_in, fifo1_in, fifo2_in, fifo3_in  output  WIDTH each  write data to FIFO 0..3.
- push0, push1, push2, push3  output  1 each  write strobe to FIFO 0..3.
- cnt_out  output  32  push statistics (see Optional Feature).

Behaviour:
- Destination: d = dato_in[DEST_LSB+1:DEST_LSB]. 00 goes to FIFO0, 01 to FIFO1, 10 to FIFO2, 11 to FIFO3. The full word, destination bits included, is forwarded unmodified.
- States: PASS and HOLD. State register, ready_out, push0..3, the shared data register and the hold register are all flops.
- Reset (reset==0): state=PASS, ready_out=0, push0..3=0, data register=0, hold register=0, counters=0. ready_out rises on the first clock edge with reset==1. Reset mid-HOLD discards the held word and asserts no push.
- fifoN_in: all four driven from one shared data register. Its value only matters when pushN=1. It holds its previous value otherwise.
- PASS, transfer with almost_full[d]==0:
  - next cycle pushd=1, fifod_in=word, other pushes 0, stay PASS, ready_out stays 1.
  - Latency is exactly 1 cycle. Back-to-back transfers give back-to-back pushes.
- PASS, transfer with almost_full[d]==1:
  - word and d are captured into the hold register; next state HOLD; ready_out=0 next cycle; no push.
- PASS, no transfer: all pushes 0 next cycle.
- HOLD:
  - ready_out=0; valid_in is ignored.
  - Each cycle, sample almost_full[held d]. If 0: next cycle push to the held destination with the held word, state PASS, ready_out=1. If 1: remain in HOLD, no push.
  - almost_full bits of other FIFOs have no effect.
- almost_full is sampled in the same cycle the decision is made. A FIFO asserting almost_full in the cycle a push is issued still receives that push. The FIFO's almost-full margin must cover this one word.
- Never more than one pushN asserted in a cycle. No word is dropped or duplicated except on reset.

Optional Feature:
- Macro: FIFO_DEMUX_STATS_EN.
- Defined:
  - four 8-bit counters, one per FIFO, each incremented on every cycle its pushN=1.
  - wrap 255 -> 0, cleared by reset.
  - cnt_out = {cnt3, cnt2, cnt1, cnt0}, registered.
- Not defined: counters absent; cnt_out tied to 32'h0. Routing behaviour is identical either way.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> all push 0, fifo*_in=0, ready_out=0 during reset; ready_out=1 one cycle after release; cnt_out=0.
- almost_full=0; send 10'h0AA, 10'h1BB, 10'h2CC, 10'h3DD on consecutive cycles -> push0..push3 pulse on consecutive cycles, each one cycle after its input, with matching data; ready_out stays 1.
- almost_full=4'b0100; send 10'h255 -> no push, ready_out=0 next cycle. Hold almost_full 3 cycles, then clear bit 2 -> push2=1 with 10'h255 the following cycle, then ready_out=1. A valid_in word presented while ready_out=0 is never pushed.
- In HOLD for FIFO1, toggle almost_full[0], [2] and [3] while almost_full[1]=1 -> no push; state stays HOLD.
- In HOLD, assert reset=0 for 1 cycle -> held word never pushed; state PASS; ready_out=1 one cycle after release.
- With FIFO_DEMUX_STATS_EN, 260 pushes to FIFO3 and 3 to FIFO0 -> cnt_out=32'h04000003. Without the macro -> cnt_out=0 throughout.

Source files
------------

// File: rtl/fifo_demux_wr.sv
// Write-side router that steers each 10-bit word to one of four FIFOs by its destination field.
// Optional per-FIFO push counters are enabled by defining FIFO_DEMUX_STATS_EN.
module fifo_demux_wr #(
  parameter int WIDTH    = 10,
  parameter int DEST_LSB = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dato_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [3:0]       almost_full,
  output logic [WIDTH-1:0] fifo0_in,
  output logic [WIDTH-1:0] fifo1_in,
  output logic [WIDTH-1:0] fifo2_in,
  output logic [WIDTH-1:0] fifo3_in,
  output logic             push0,
  output logic             push1,
  output logic             push2,
  output logic             push3,
  output logic [31:0]      cnt_out
);

  typedef enum logic [0:0] {
    PASS = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic             ready_q;
  logic [3:0]       push_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] hold_q;
  logic [1:0]       hold_dest_q;
  logic [1:0]       dest_s;
  logic             xfer_s;

  assign dest_s = dato_in[DEST_LSB +: 2];
  assign xfer_s = valid_in & ready_q;

  // Routing FSM: every output it drives is a flop
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= PASS;
      ready_q     <= 1'b0;
      push_q      <= 4'b0000;
      data_q      <= {WIDTH{1'b0}};
      hold_q      <= {WIDTH{1'b0}};
      hold_dest_q <= 2'b00;
    end else begin
      case (state_q)
        PASS: begin
          if (xfer_s && !almost_full[dest_s]) begin
            push_q  <= 4'b0001 << dest_s;
            data_q  <= dato_in;
            ready_q <= 1'b1;
          end else if (xfer_s) begin
            // Destination is almost full: park the word until it drains
            push_q      <= 4'b0000;
            hold_q      <= dato_in;
            hold_dest_q <= dest_s;
            ready_q     <= 1'b0;
            state_q     <= HOLD;
          end else begin
            push_q  <= 4'b0000;
            ready_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!almost_full[hold_dest_q]) begin
            push_q  <= 4'b0001 << hold_dest_q;
            data_q  <= hold_q;
            ready_q <= 1'b1;
            state_q <= PASS;
          end else begin
            push_q  <= 4'b0000;
            ready_q <= 1'b0;
          end
        end
        default: begin
          push_q  <= 4'b0000;
          ready_q <= 1'b0;
          state_q <= PASS;
        end
      endcase
    end
  end

  assign ready_out = ready_q;
  assign fifo0_in  = data_q;
  assign fifo1_in  = data_q;
  assign fifo2_in  = data_q;
  assign fifo3_in  = data_q;
  assign push0     = push_q[0];
  assign push1     = push_q[1];
  assign push2     = push_q[2];
  assign push3     = push_q[3];

`ifdef FIFO_DEMUX_STATS_EN
  logic [3:0][7:0] cnt_q;
  logic [3:0][7:0] cnt_d;

  // Next count: each counter wraps naturally at 8 bits
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (push_q[i]) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out = cnt_q;
`else
  assign cnt_out = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fifo_demux_wr.sv
// Scoreboard bench for fifo_demux_wr: expected pushes are queued at stimulus time and
// matched against the DUT's push strobes on the falling clock edge.
module tb_fifo_demux_wr;

  typedef struct {
    int         cyc;
    logic [1:0] d;
    logic [9:0] w;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [9:0]  dato_in;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  almost_full;
  logic [9:0]  fifo0_in, fifo1_in, fifo2_in, fifo3_in;
  logic        push0, push1, push2, push3;
  logic [31:0] cnt_out;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] mon_pv;
  logic [9:0] mon_data;
  logic [31:0] cnt_exp;

  fifo_demux_wr dut (
    .clk(clk), .reset(reset), .dato_in(dato_in), .valid_in(valid_in),
    .ready_out(ready_out), .almost_full(almost_full),
    .fifo0_in(fifo0_in), .fifo1_in(fifo1_in), .fifo2_in(fifo2_in), .fifo3_in(fifo3_in),
    .push0(push0), .push1(push1), .push2(push2), .push3(push3),
    .cnt_out(cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word; if a push is expected, it is due the next cycle
  task automatic send(input logic [9:0] w, input bit expect_push);
    exp_t e;
    valid_in = 1'b1;
    dato_in  = w;
    if (expect_push) begin
      e.cyc = cyc + 1;
      e.d   = w[9:8];
      e.w   = w;
      sb.push_back(e);
    end
    step();
    valid_in = 1'b0;
  endtask

  task automatic expect_at_next(input logic [9:0] w);
    exp_t e;
    e.cyc = cyc + 1;
    e.d   = w[9:8];
    e.w   = w;
    sb.push_back(e);
  endtask

  // Push monitor: each strobe must match the oldest expectation, in its cycle
  always @(negedge clk) begin
    mon_pv = {push3, push2, push1, push0};
    if (mon_pv != 4'b0000) begin
      chk("push_onehot", $countones(mon_pv), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_push", {28'd0, mon_pv}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        case (mon_e.d)
          2'd0:    mon_data = fifo0_in;
          2'd1:    mon_data = fifo1_in;
          2'd2:    mon_data = fifo2_in;
          default: mon_data = fifo3_in;
        endcase
        chk("push_cycle", cyc, mon_e.cyc);
        chk("push_dest", {28'd0, mon_pv}, {28'd0, 4'b0001 << mon_e.d});
        chk("push_data", {22'd0, mon_data}, {22'd0, mon_e.w});
      end
    end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
      chk("missing_push", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    logic [9:0] words [4];
    words[0] = 10'h0AA; words[1] = 10'h1BB; words[2] = 10'h2CC; words[3] = 10'h3DD;
    reset = 1'b0; valid_in = 1'b0; dato_in = 10'h000; almost_full = 4'b0000;

    // Reset for two edges
    step(); step();
    chk("rst_ready", {31'd0, ready_out}, 32'd0);
    chk("rst_push", {28'd0, push3, push2, push1, push0}, 32'd0);
    chk("rst_fifo0", {22'd0, fifo0_in}, 32'd0);
    chk("rst_fifo3", {22'd0, fifo3_in}, 32'd0);
    chk("rst_cnt", cnt_out, 32'd0);
    reset = 1'b1;
    step();
    chk("ready_after_rst", {31'd0, ready_out}, 32'd1);

    // Back-to-back routing to all four FIFOs
    for (int i = 0; i < 4; i++) begin
      send(words[i], 1'b1);
      chk("b2b_ready", {31'd0, ready_out}, 32'd1);
    end
    step(); step();

    // FIFO2 almost full: word is held, later pushed; words offered meanwhile are ignored
    almost_full = 4'b0100;
    send(10'h255, 1'b0);
    chk("hold_ready", {31'd0, ready_out}, 32'd0);
    valid_in = 1'b1; dato_in = 10'h0C3;
    step(); step(); step();
    chk("hold_ready_3", {31'd0, ready_out}, 32'd0);
    almost_full = 4'b0000; valid_in = 1'b0;
    expect_at_next(10'h255);
    step();
    chk("release_ready", {31'd0, ready_out}, 32'd1);
    step(); step();

    // Hold on FIFO1: other almost_full bits must not release it
    almost_full = 4'b0010;
    send(10'h15A, 1'b0);
    for (int i = 0; i < 6; i++) begin
      almost_full = 4'($urandom) | 4'b0010;
      step();
      chk("hold1_ready", {31'd0, ready_out}, 32'd0);
    end
    almost_full = 4'b1101;
    expect_at_next(10'h15A);
    step();
    chk("hold1_release_ready", {31'd0, ready_out}, 32'd1);
    almost_full = 4'b0000;
    step(); step();

    // Reset while holding discards the held word
    almost_full = 4'b1000;
    send(10'h3F0, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("midhold_rst_ready", {31'd0, ready_out}, 32'd0);
    reset = 1'b1; almost_full = 4'b0000;
    step();
    chk("midhold_ready", {31'd0, ready_out}, 32'd1);
    chk("midhold_cnt", cnt_out, 32'd0);
    step(); step(); step();

    // Statistics: 260 pushes to FIFO3, 3 to FIFO0
    for (int i = 0; i < 260; i++) send({2'b11, 8'(i)}, 1'b1);
    for (int i = 0; i < 3; i++) send({2'b00, 8'(i + 16)}, 1'b1);
    step(); step();
`ifdef FIFO_DEMUX_STATS_EN
    cnt_exp = 32'h0400_0003;
`else
    cnt_exp = 32'h0000_0000;
`endif
    chk("cnt_out", cnt_out, cnt_exp);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
